alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences the combinational signed 8x8 ALU datapath (2-bit select S_1/S_0, A, B -> 16-bit R) from board inputs.
//  Debounces the push button, latches operands and op select on a clean press, holds them stable through a settle window,
//  then captures R into a result register and pulses done. Sits between board switches/button and the ALU + 7-seg driver.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable clk cycles before a button level change is accepted (>=2)
//  SETTLE_CYCLES    4          cycles operands are held on the datapath before R is sampled (>=1)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  button     in   1   raw asynchronous push button, active-high
//  sel_in     in   2   op select from switches {S_1,S_0}
//  a_in       in   8   signed operand A from switches
//  b_in       in   8   signed operand B from switches
//  dp_s1      out  1   datapath select bit 1 (registered)
//  dp_s0      out  1   datapath select bit 0 (registered)
//  dp_a       out  8   datapath operand A (registered)
//  dp_b       out  8   datapath operand B (registered)
//  dp_r       in   16  signed datapath result
//  result     out  16  captured signed result, held until next capture
//  done       out  1   one-cycle pulse on the cycle result updates
//  busy       out  1   high in LOAD, EXEC, CAPTURE
//  op_count   out  8   completed operations, wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; sync flops, debounced level and counters 0.
//  Input sync: button passes 2 flops (b_s1, b_s2) before any use.
//  Debounce: when b_s2 != btn_stable, count++; when b_s2 == btn_stable, count=0.
//   When count reaches DEBOUNCE_CYCLES-1 with b_s2 still different: btn_stable <= b_s2, count <= 0.
//  press: registered 1-cycle pulse on the 0->1 transition of btn_stable. Release edges are ignored.
//  FSM:
//   IDLE    -> LOAD on press; otherwise stay.
//   LOAD    -> EXEC (1 cycle). dp_s1/dp_s0/dp_a/dp_b <= sel_in/a_in/b_in; settle counter <= 0.
//   EXEC    -> count SETTLE_CYCLES cycles; on the last cycle -> CAPTURE. dp_* held constant.
//   CAPTURE -> IDLE (1 cycle). result <= dp_r; done=1; op_count <= op_count+1 (mod 256).
//  Latency: the press pulse to the done pulse is SETTLE_CYCLES+2 clk cycles.
//   done is in the same cycle that result changes.
//  press while busy: dropped, not queued. Switch changes after LOAD do not affect the running op.
//  dp_* outputs hold the last operands in IDLE, so R stays displayable. result changes only in CAPTURE.
//  Reset mid-operation (any state): the next cycle matches the post-reset values.
//   No done pulse; the partial op is discarded; op_count=0.
//  A button glitch shorter than DEBOUNCE_CYCLES produces no press.
//  A button held high produces exactly one press.
//  Width: result is a direct 16-bit copy of dp_r; the block does no arithmetic on operands.
// STRUCTURE
//  Package alu_pkg:
//   typedef enum logic [1:0] op_e {OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_NEG_A=2'b11}
//   typedef enum logic [1:0] seq_state_e {IDLE, LOAD, EXEC, CAPTURE}
//   localparam DATA_W=8, RES_W=16
//  Sub-module button_debouncer (clk, reset, raw, stable_level, rise_pulse), parameterised by DEBOUNCE_CYCLES.
//   Reused later for the reset/display buttons.
//  Top: FSM, settle counter, operand/result registers, op_count.
// TESTING
//  All runs: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=4; bench drives dp_r from a behavioural model of the op_e encoding.
//  1. sel=00, a=5, b=3, button held 10 cycles:
//     exactly one done, result=8, op_count=1, done 6 cycles after press.
//  2. Repeat with sel=01, then sel=10 (a=5, b=3):
//     result=2, then 15; op_count=3.
//  3. sel=10, a=8'hE5 (-27), b=8'hE8 (-24):
//     result=16'h0288 (648). Then a=-27, b=24: result=16'hFD78 (-648).
//  4. Button pulses of 1-3 cycles high -> no done, busy stays 0.
//     Second clean press during EXEC -> ignored; exactly one done.
//  5. Assert reset in EXEC -> next cycle: busy=0, dp_*=0, result=0, op_count=0, no done.
//     A following clean press completes normally.
//  6. 256 completed ops -> op_count wraps to 0. In IDLE, changing a_in/sel_in leaves dp_* and result unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand sequencer.
// Op encoding mirrors the datapath's {S_1,S_0} select.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_MUL   = 2'b10,
    OP_NEG_A = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    CAPTURE
  } seq_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus counter debounce for a raw push button.
// rise_pulse is a registered one-cycle pulse on each accepted 0->1 change.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable_level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          b_s1_q, b_s1_d;
  logic          b_s2_q, b_s2_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    b_s1_d   = raw;
    b_s2_d   = b_s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (b_s2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = b_s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_s1_q   <= 1'b0;
      b_s2_q   <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      b_s1_q   <= b_s1_d;
      b_s2_q   <= b_s2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_level = stable_q;
  assign rise_pulse   = rise_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Latches switch operands on a clean press, lets the ALU settle,
// then captures R and pulses done alongside the result update.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button,
  input  logic [1:0]        sel_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              dp_s1,
  output logic              dp_s0,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  input  logic [RES_W-1:0]  dp_r,
  output logic [RES_W-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic [7:0]        op_count
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic btn_level, btn_rise, press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk         (clk),
    .reset       (reset),
    .raw         (button),
    .stable_level(btn_level),
    .rise_pulse  (btn_rise)
  );

  assign press = btn_rise & btn_level;

  seq_state_e        state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (press) state_d = LOAD;
      end
      LOAD: begin
        state_d  = EXEC;
        sel_d    = sel_in;
        a_d      = a_in;
        b_d      = b_in;
        settle_d = '0;
      end
      EXEC: begin
        // capture on the last settle cycle so done and result move together
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d  = CAPTURE;
          result_d = dp_r;
          done_d   = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dp_s1    = sel_q[1];
  assign dp_s0    = sel_q[0];
  assign dp_a     = a_q;
  assign dp_b     = b_q;
  assign result   = result_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on dp_r.
// A second instance with a long settle window covers press-while-busy.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        button = 1'b0;
  logic        button2 = 1'b0;
  logic [1:0]  sel_in = 2'b00;
  logic [7:0]  a_in = 8'd0;
  logic [7:0]  b_in = 8'd0;

  logic        dp_s1, dp_s0, done, busy;
  logic [7:0]  dp_a, dp_b, op_count;
  logic [15:0] dp_r, result;

  logic        s_dp_s1, s_dp_s0, s_done, s_busy;
  logic [7:0]  s_dp_a, s_dp_b, s_op_count;
  logic [15:0] s_dp_r, s_result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [1:0] s,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic signed [15:0] ae, be;
    ae = 16'(signed'(a));
    be = 16'(signed'(b));
    case (s)
      2'b00:   return ae + be;
      2'b01:   return ae - be;
      2'b10:   return ae * be;
      default: return -ae;
    endcase
  endfunction

  always_comb dp_r = alu_model({dp_s1, dp_s0}, dp_a, dp_b);
  always_comb s_dp_r = alu_model({s_dp_s1, s_dp_s0}, s_dp_a, s_dp_b);

  alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .button(button),
    .sel_in(sel_in), .a_in(a_in), .b_in(b_in),
    .dp_s1(dp_s1), .dp_s0(dp_s0), .dp_a(dp_a), .dp_b(dp_b),
    .dp_r(dp_r), .result(result), .done(done), .busy(busy),
    .op_count(op_count)
  );

  alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(16)) u_slow (
    .clk(clk), .reset(reset), .button(button2),
    .sel_in(sel_in), .a_in(a_in), .b_in(b_in),
    .dp_s1(s_dp_s1), .dp_s0(s_dp_s0), .dp_a(s_dp_a), .dp_b(s_dp_b),
    .dp_r(s_dp_r), .result(s_result), .done(s_done), .busy(s_busy),
    .op_count(s_op_count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Button rises at a negedge; k-th negedge after it follows k posedges.
  task automatic run_op(input logic [1:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input int hold,
                        input int window, output int nd,
                        output int lat, output int bsy);
    sel_in = sel; a_in = a; b_in = b;
    nd = 0; lat = -1; bsy = 0;
    button = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (k == hold) button = 1'b0;
      if (k == 8) begin
        sel_in = ~sel; a_in = ~a; b_in = ~b;
      end
      if (busy) bsy = 1;
      if (done) begin
        nd++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_r;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int nd, lat, bsy;
    vecs[0] = '{2'b00, 8'd5,   8'd3,   16'd8};
    vecs[1] = '{2'b01, 8'd5,   8'd3,   16'd2};
    vecs[2] = '{2'b10, 8'd5,   8'd3,   16'd15};
    vecs[3] = '{2'b10, 8'hE5,  8'hE8,  16'h0288};
    vecs[4] = '{2'b10, 8'hE5,  8'h18,  16'hFD78};
    vecs[5] = '{2'b11, 8'd5,   8'd3,   16'hFFFB};

    repeat (3) @(negedge clk);
    chk("rst_outs", {dp_s1, dp_s0, dp_a, dp_b, done, busy}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_count", {24'd0, op_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2 sync + 4 debounce edges to press, then 6 more to done = 12
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 10, 30, nd, lat, bsy);
      chk($sformatf("v%0d_ndone", i), nd, 1);
      chk($sformatf("v%0d_lat", i), lat, 12);
      chk($sformatf("v%0d_result", i), {16'd0, result},
          {16'd0, vecs[i].exp_r});
      chk($sformatf("v%0d_count", i), {24'd0, op_count}, i + 1);
      chk($sformatf("v%0d_dp", i), {dp_s1, dp_s0, dp_a, dp_b},
          {vecs[i].sel, vecs[i].a, vecs[i].b});
    end

    for (int h = 1; h <= 3; h++) begin
      run_op(2'b00, 8'd1, 8'd1, h, 20, nd, lat, bsy);
      chk($sformatf("glitch%0d_ndone", h), nd, 0);
      chk($sformatf("glitch%0d_busy", h), bsy, 0);
    end
    chk("glitch_count", {24'd0, op_count}, 32'd6);

    // second clean press lands while the slow instance is in EXEC
    sel_in = 2'b00; a_in = 8'd7; b_in = 8'd9;
    nd = 0; lat = -1;
    button2 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 4) button2 = 1'b0;
      if (k == 8) button2 = 1'b1;
      if (k == 16) button2 = 1'b0;
      if (k == 14) chk("slow_busy_at_press", {31'd0, s_busy}, 32'd1);
      if (s_done) begin
        nd++;
        if (lat < 0) lat = k;
      end
    end
    chk("slow_ndone", nd, 1);
    chk("slow_lat", lat, 24);
    chk("slow_result", {16'd0, s_result}, 32'd16);
    chk("slow_count", {24'd0, s_op_count}, 32'd1);

    // reset while in EXEC
    sel_in = 2'b01; a_in = 8'd9; b_in = 8'd2;
    button = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 4) button = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_outs", {dp_s1, dp_s0, dp_a, dp_b, done, busy}, 32'd0);
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_count", {24'd0, op_count}, 32'd0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_nodone", nd, 0);
    run_op(2'b01, 8'd9, 8'd2, 4, 20, nd, lat, bsy);
    chk("post_rst_ndone", nd, 1);
    chk("post_rst_result", {16'd0, result}, 32'd7);
    chk("post_rst_count", {24'd0, op_count}, 32'd1);

    begin
      int tot_done = 0;
      for (int i = 0; i < 254; i++) begin
        run_op(2'(i), 8'(i), 8'd3, 4, 20, nd, lat, bsy);
        tot_done += nd;
      end
      chk("wrap_ndone", tot_done, 254);
    end
    chk("wrap_pre_count", {24'd0, op_count}, 32'd255);
    run_op(2'b11, 8'd5, 8'd0, 4, 20, nd, lat, bsy);
    chk("wrap_count", {24'd0, op_count}, 32'd0);
    chk("wrap_result", {16'd0, result}, 32'hFFFB);

    sel_in = 2'b00; a_in = 8'd77; b_in = 8'd66;
    repeat (10) @(negedge clk);
    chk("idle_dp", {8'd0, dp_s1, dp_s0, 6'd0, dp_a, dp_b},
        {8'd0, 2'b11, 6'd0, 8'd5, 8'd0});
    chk("idle_result", {16'd0, result}, 32'hFFFB);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
